// File: rtl/coin_accumulator_pkg.sv
// Shared types for the coin accumulator: FSM state encoding, coin codes and
// the coin-code to rupee value mapping.
package coin_acc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OFFER   = 2'd2,
      REFUND  = 2'd3
   } state_t;

   localparam logic [1:0] COIN_5  = 2'b00;
   localparam logic [1:0] COIN_10 = 2'b01;
   localparam logic [1:0] COIN_20 = 2'b10;
   localparam logic [1:0] COIN_50 = 2'b11;

   function automatic logic [7:0] coin_value(input logic [1:0] code);
      logic [7:0] v;
      v = 8'd0;
      case (code)
         COIN_5:  v = 8'd5;
         COIN_10: v = 8'd10;
         COIN_20: v = 8'd20;
         COIN_50: v = 8'd50;
         default: v = 8'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin-slot / vend-stage bus of the coin accumulator. master drives the
// customer and downstream inputs, slave is the accumulator itself.
interface coin_acc_if #(
   parameter int CW = 8
);
   logic          coin_valid;
   logic [1:0]    coin_type;
   logic          confirm;
   logic          cancel;
   logic          vend_ack;
   logic [CW-1:0] money_out;
   logic          money_valid;
   logic [CW-1:0] refund;
   logic          refund_valid;
   logic          coin_reject;
   logic [CW-1:0] credit;

   modport master (
      output coin_valid, coin_type, confirm, cancel, vend_ack,
      input  money_out, money_valid, refund, refund_valid, coin_reject, credit
   );

   modport slave (
      input  coin_valid, coin_type, confirm, cancel, vend_ack,
      output money_out, money_valid, refund, refund_valid, coin_reject, credit
   );
endinterface

// File: rtl/coin_accumulator_inactivity_timer.sv
// Idle-cycle counter: expired is high on the cycle the count has reached
// TIMEOUT_CYCLES-1 while enabled and not being cleared.
module inactivity_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable && (r_count != LAST)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = enable && !clear && (r_count == LAST);

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator front end: sums coins into credit, offers it on confirm,
// refunds on cancel. Macro COIN_ACC_TIMEOUT_EN adds the inactivity auto-refund.
module coin_accumulator
   import coin_acc_pkg::*;
#(
   parameter int CW             = 8,
   parameter int MAX_CREDIT     = 200,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic     clk,
   input  logic     reset,
   coin_acc_if.slave bus
);
   state_t        r_state;
   logic [CW-1:0] r_credit;
   logic [CW-1:0] r_money_out;
   logic          r_money_valid;
   logic [CW-1:0] r_refund;
   logic          r_refund_valid;
   logic          r_coin_reject;

   logic [CW:0]   w_coin_val;
   logic [CW:0]   w_sum;
   logic          w_accept;
   logic [CW-1:0] w_credit_post;
   logic          w_tmr_en;
   logic          w_tmr_clr;
   logic          w_expired;

   // Sum is one bit wider than credit so an overflowing coin is rejected, not wrapped.
   assign w_coin_val    = (CW+1)'(coin_value(bus.coin_type));
   assign w_sum         = {1'b0, r_credit} + w_coin_val;
   assign w_accept      = bus.coin_valid && (w_sum <= (CW+1)'(MAX_CREDIT)) &&
                          ((r_state == IDLE) || (r_state == COLLECT));
   assign w_credit_post = w_accept ? w_sum[CW-1:0] : r_credit;

   assign w_tmr_en  = (r_state == COLLECT);
   assign w_tmr_clr = !w_tmr_en || w_accept;

`ifdef COIN_ACC_TIMEOUT_EN
   inactivity_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_tmr_clr),
      .enable  (w_tmr_en),
      .expired (w_expired)
   );
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^{w_tmr_en, w_tmr_clr, 32'(TIMEOUT_CYCLES)};
   assign w_expired    = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_credit       <= '0;
         r_money_out    <= '0;
         r_money_valid  <= 1'b0;
         r_refund       <= '0;
         r_refund_valid <= 1'b0;
         r_coin_reject  <= 1'b0;
      end else begin
         r_coin_reject  <= bus.coin_valid && !w_accept;
         r_refund_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_credit <= w_credit_post;
               if (w_accept) begin
                  r_state <= COLLECT;
               end
            end
            COLLECT: begin
               r_credit <= w_credit_post;
               // cancel outranks confirm; the same-cycle coin is already in w_credit_post
               if (bus.cancel || (w_expired && !bus.confirm)) begin
                  r_refund       <= w_credit_post;
                  r_refund_valid <= 1'b1;
                  r_state        <= REFUND;
               end else if (bus.confirm && (w_credit_post != '0)) begin
                  r_money_out   <= w_credit_post;
                  r_money_valid <= 1'b1;
                  r_state       <= OFFER;
               end
            end
            OFFER: begin
               if (bus.vend_ack) begin
                  r_money_out   <= '0;
                  r_money_valid <= 1'b0;
                  r_credit      <= '0;
                  r_state       <= IDLE;
               end
            end
            REFUND: begin
               r_credit <= '0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.money_out    = r_money_out;
   assign bus.money_valid  = r_money_valid;
   assign bus.refund       = r_refund;
   assign bus.refund_valid = r_refund_valid;
   assign bus.coin_reject  = r_coin_reject;
   assign bus.credit       = r_credit;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed self-checking bench for coin_accumulator; expected values are
// hand-computed. Timeout checks follow COIN_ACC_TIMEOUT_EN.
module tb_coin_accumulator;
   import coin_acc_pkg::*;

   logic clk;
   logic reset;
   int unsigned n_checks;
   int unsigned n_errors;

   coin_acc_if #(.CW(8)) bus ();

   coin_accumulator #(
      .CW             (8),
      .MAX_CREDIT     (200),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] code);
      bus.coin_valid = 1'b1;
      bus.coin_type  = code;
      cyc();
      bus.coin_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset          = 1'b1;
      bus.coin_valid = 1'b0;
      bus.coin_type  = 2'b00;
      bus.confirm    = 1'b0;
      bus.cancel     = 1'b0;
      bus.vend_ack   = 1'b0;
      cyc();
      cyc();
      check("rst_credit", 32'(bus.credit), 0);
      check("rst_money_out", 32'(bus.money_out), 0);
      check("rst_money_valid", 32'(bus.money_valid), 0);
      check("rst_refund", 32'(bus.refund), 0);
      check("rst_refund_valid", 32'(bus.refund_valid), 0);
      check("rst_coin_reject", 32'(bus.coin_reject), 0);
      reset = 1'b0;
      cyc();

      // confirm ignored in IDLE
      bus.confirm = 1'b1;
      cyc();
      bus.confirm = 1'b0;
      check("idle_confirm_valid", 32'(bus.money_valid), 0);

      // 20 + 5, confirm, vend_ack after 3 cycles
      coin(COIN_20);
      check("t1_credit20", 32'(bus.credit), 20);
      coin(COIN_5);
      check("t1_credit25", 32'(bus.credit), 25);
      bus.confirm = 1'b1;
      cyc();
      bus.confirm = 1'b0;
      check("t1_valid_c1", 32'(bus.money_valid), 1);
      check("t1_out_c1", 32'(bus.money_out), 25);
      cyc();
      check("t1_valid_c2", 32'(bus.money_valid), 1);
      check("t1_out_c2", 32'(bus.money_out), 25);
      cyc();
      check("t1_valid_c3", 32'(bus.money_valid), 1);
      check("t1_out_c3", 32'(bus.money_out), 25);
      bus.vend_ack = 1'b1;
      cyc();
      bus.vend_ack = 1'b0;
      check("t1_valid_after_ack", 32'(bus.money_valid), 0);
      check("t1_out_after_ack", 32'(bus.money_out), 0);
      check("t1_credit_after_ack", 32'(bus.credit), 0);
      bus.vend_ack = 1'b1;
      cyc();
      bus.vend_ack = 1'b0;
      check("idle_ack_ignored", 32'(bus.money_valid), 0);

      // 4 x 50 reaches the limit exactly, a further 5 is rejected
      for (int unsigned i = 1; i <= 4; i++) begin
         coin(COIN_50);
         check("t2_credit_step", 32'(bus.credit), 32'(50 * i));
         check("t2_no_reject", 32'(bus.coin_reject), 0);
      end
      coin(COIN_5);
      check("t2_reject", 32'(bus.coin_reject), 1);
      check("t2_credit_held", 32'(bus.credit), 200);
      cyc();
      check("t2_reject_one_cycle", 32'(bus.coin_reject), 0);
      bus.cancel = 1'b1;
      cyc();
      bus.cancel = 1'b0;
      check("t2_refund_valid", 32'(bus.refund_valid), 1);
      check("t2_refund", 32'(bus.refund), 200);
      cyc();
      check("t2_refund_valid_drop", 32'(bus.refund_valid), 0);
      check("t2_credit_clear", 32'(bus.credit), 0);

      // 50 + 10, cancel and confirm together: cancel wins; coin during REFUND rejected
      coin(COIN_50);
      coin(COIN_10);
      check("t3_credit60", 32'(bus.credit), 60);
      bus.cancel  = 1'b1;
      bus.confirm = 1'b1;
      cyc();
      bus.cancel  = 1'b0;
      bus.confirm = 1'b0;
      check("t3_refund_valid", 32'(bus.refund_valid), 1);
      check("t3_refund", 32'(bus.refund), 60);
      check("t3_no_offer", 32'(bus.money_valid), 0);
      coin(COIN_5);
      check("t3_refund_one_cycle", 32'(bus.refund_valid), 0);
      check("t3_refund_state_reject", 32'(bus.coin_reject), 1);
      check("t3_credit_idle", 32'(bus.credit), 0);
      check("t3_refund_held", 32'(bus.refund), 60);
      check("t3_still_no_offer", 32'(bus.money_valid), 0);

      // coin in the same cycle as cancel is included in the refund
      coin(COIN_20);
      bus.cancel = 1'b1;
      coin(COIN_10);
      bus.cancel = 1'b0;
      check("t3b_refund_valid", 32'(bus.refund_valid), 1);
      check("t3b_refund", 32'(bus.refund), 30);
      cyc();

      // coin with confirm lands in money_out; coin + cancel in OFFER are rejected/ignored
      coin(COIN_20);
      bus.confirm = 1'b1;
      coin(COIN_10);
      bus.confirm = 1'b0;
      check("t4_valid", 32'(bus.money_valid), 1);
      check("t4_out30", 32'(bus.money_out), 30);
      bus.cancel = 1'b1;
      coin(COIN_10);
      bus.cancel = 1'b0;
      check("t4_reject", 32'(bus.coin_reject), 1);
      check("t4_no_refund", 32'(bus.refund_valid), 0);
      check("t4_valid_held", 32'(bus.money_valid), 1);
      check("t4_out_held", 32'(bus.money_out), 30);
      cyc();
      check("t4_reject_one_cycle", 32'(bus.coin_reject), 0);
      check("t4_out_held2", 32'(bus.money_out), 30);
      bus.vend_ack = 1'b1;
      cyc();
      bus.vend_ack = 1'b0;
      check("t4_valid_drop", 32'(bus.money_valid), 0);
      check("t4_credit_clear", 32'(bus.credit), 0);

      // inactivity: coin 10 then idle
      coin(COIN_10);
      check("t5_credit10", 32'(bus.credit), 10);
`ifdef COIN_ACC_TIMEOUT_EN
      for (int unsigned k = 1; k <= 7; k++) begin
         cyc();
         check("t5_no_early_refund", 32'(bus.refund_valid), 0);
      end
      cyc();
      check("t5_timeout_refund_valid", 32'(bus.refund_valid), 1);
      check("t5_timeout_refund", 32'(bus.refund), 10);
      cyc();
      check("t5_timeout_one_cycle", 32'(bus.refund_valid), 0);
      check("t5_timeout_credit", 32'(bus.credit), 0);
`else
      for (int unsigned k = 1; k <= 30; k++) begin
         cyc();
         check("t5_no_refund", 32'(bus.refund_valid), 0);
      end
      check("t5_credit_holds", 32'(bus.credit), 10);
      bus.cancel = 1'b1;
      cyc();
      bus.cancel = 1'b0;
      check("t5_cancel_refund", 32'(bus.refund), 10);
      cyc();
`endif

      // async reset between edges while in OFFER
      coin(COIN_50);
      bus.confirm = 1'b1;
      cyc();
      bus.confirm = 1'b0;
      check("t6_pre_valid", 32'(bus.money_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_valid_drop", 32'(bus.money_valid), 0);
      check("t6_credit_drop", 32'(bus.credit), 0);
      check("t6_out_drop", 32'(bus.money_out), 0);
      check("t6_no_refund", 32'(bus.refund_valid), 0);
      cyc();
      check("t6_no_refund_hold", 32'(bus.refund_valid), 0);
      reset = 1'b0;
      cyc();
      check("t6_post_no_refund", 32'(bus.refund_valid), 0);
      check("t6_post_credit", 32'(bus.credit), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
- Upstream front end of smart_vending_machine.
- Turns discrete coin-slot events into one accumulated credit value, and presents that value on money_out/money_valid when the customer confirms.
- Holds the value until the vending stage acknowledges it.
- Handles cancel and inactivity refunds, and rejects coins that would push credit past the machine limit.

Parameters:
- CW, 8: credit/value width in bits; matches money_inserted width.
- MAX_CREDIT, 200: maximum accumulated credit in ₹; must be ≤ 2^CW-1.
- TIMEOUT_CYCLES, 1000: idle cycles in COLLECT before auto-refund; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe: one coin present this cycle.
- coin_type  in  2  coin value code: 00=₹5, 01=₹10, 10=₹20, 11=₹50.
- confirm  in  1  level; customer commits the current credit.
- cancel  in  1  level; customer requests a refund.
- vend_ack  in  1  downstream has consumed money_out.
- money_out  out  CW  committed credit; drives money_inserted downstream.
- money_valid  out  1  money_out is valid and held stable.
- refund  out  CW  amount to return.
- refund_valid  out  1  one-cycle strobe qualifying refund.
- coin_reject  out  1  one-cycle strobe: the coin this cycle was returned to the tray.
- credit  out  CW  live accumulated credit, for the display.

Behaviour:
- Reset (async, active-high): state=IDLE; credit, money_out, refund = 0; money_valid, refund_valid, coin_reject = 0; timer=0.
- Outputs are registered. Every response appears on the cycle after the triggering input.
- States: IDLE, COLLECT, OFFER, REFUND.
- IDLE:
  - credit=0.
  - An accepted coin loads credit=value and moves to COLLECT.
  - confirm and cancel are ignored.
- COLLECT:
  - Accepted coin: credit += value; timer cleared.
  - Coin rejected when credit+value > MAX_CREDIT. Sum is computed at CW+1 bits, so no wrap. On reject, coin_reject pulses and credit is unchanged.
  - A coin at exactly MAX_CREDIT total is accepted.
  - confirm with post-coin credit > 0: go to OFFER; money_out=credit; money_valid=1.
  - cancel: go to REFUND.
  - cancel and confirm in the same cycle: cancel wins.
  - Coin in the same cycle as confirm or cancel: coin is evaluated first, and its value is included in money_out or refund.
- OFFER:
  - money_valid and money_out held stable until vend_ack=1. Then next cycle: money_valid=0, money_out=0, credit=0, state=IDLE.
  - coin_valid gets coin_reject. cancel and confirm are ignored (credit is committed).
  - vend_ack outside OFFER is ignored.
- REFUND:
  - Single cycle: refund=credit, refund_valid=1; then credit=0, state=IDLE.
  - A coin arriving in this cycle is rejected.
  - refund holds its value until the next refund, but is qualified only by refund_valid.
- Timeout: in COLLECT, timer counts cycles with no accepted coin. When timer reaches TIMEOUT_CYCLES-1 the state goes to REFUND. A rejected coin does not clear the timer.
- Reset mid-OFFER or mid-REFUND aborts immediately. No refund pulse is produced, and credit is lost by design; the coin mechanism handles physical return.
- coin_reject and refund_valid are never asserted for more than one consecutive cycle per event.

Optional Feature:
- COIN_ACC_TIMEOUT_EN defined: the inactivity timer and its auto-refund from COLLECT are compiled in, as described above.
- Undefined: no timer logic. COLLECT is left only via confirm or cancel. TIMEOUT_CYCLES is unused.

Decomposition:
- Package coin_acc_pkg holds:
  - the state enum (IDLE, COLLECT, OFFER, REFUND);
  - coin code localparams COIN_5/10/20/50;
  - a constant function mapping coin_type to ₹ value.
- One sub-module, inactivity_timer (inputs: clear, enable; output: expired). It is instantiated only under COIN_ACC_TIMEOUT_EN.
- Credit/FSM logic stays in coin_accumulator.

Test Plan:
- Coins ₹20, ₹5; confirm; vend_ack after 3 cycles -> credit 20 then 25; money_valid=1 with money_out=25 held 3 cycles; then money_valid=0, credit=0.
- Coins 4×₹50 (200), then ₹5 -> fourth coin accepted at credit=200; ₹5 coin gets coin_reject, credit stays 200.
- Coin ₹50 + ₹10; cancel and confirm asserted in the same cycle -> refund_valid 1 cycle with refund=60; money_valid never asserts; state IDLE.
- In OFFER with money_out=30: insert ₹10 and assert cancel -> coin_reject pulses; cancel ignored; money_out stays 30 until vend_ack.
- With COIN_ACC_TIMEOUT_EN, TIMEOUT_CYCLES=8: coin ₹10, then idle -> refund_valid with refund=10 exactly 8 cycles after the coin; without the macro, credit holds 10 indefinitely.
- Reset asserted mid-OFFER (async, between edges) -> money_valid, credit, money_out drop to 0 immediately; no refund_valid pulse.
